// File: rtl/combi_chk_pkg.sv
// Shared definitions for the combinational response checker: FSM encoding,
// vector count and derived widths.
package combi_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    // Mismatch counter must represent 0..VEC_COUNT inclusive.
    localparam int CNT_W     = $clog2(VEC_COUNT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

endpackage

// File: rtl/combi_settle_cnt.sv
// Settle-time counter: cleared by load, advances while count is high and
// stops at the terminal value, where tc is raised.
module combi_settle_cnt
    import combi_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic tc
);

    // tc marks the last settle cycle, so SETTLE lasts SETTLE_CYCLES cycles.
    localparam logic [IDX_W-1:0] TC_VAL = IDX_W'(SETTLE_CYCLES - 1);

    logic [IDX_W-1:0] r_cnt;

    // Counter register: load wins over count; holds once terminal is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (count && !tc) begin
            r_cnt <= r_cnt + IDX_W'(1);
        end
    end

    assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/combi_resp_checker.sv
// Exhaustive truth-table checker for a 4-input combinational unit: sweeps all
// 16 input vectors, lets each settle, samples the response and compares it
// with a golden table latched at start.
module combi_resp_checker
    import combi_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [VEC_COUNT-1:0] expected,
    input  logic                 y_in,
    output logic [IDX_W-1:0]     abcd,
    output logic [VEC_COUNT-1:0] cap,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [IDX_W-1:0]     first_fail
);

    state_t                 r_state;
    state_t                 w_next;
    logic [IDX_W-1:0]       r_idx;
    logic [VEC_COUNT-1:0]   r_exp;
    logic [VEC_COUNT-1:0]   r_cap;
    logic [CNT_W-1:0]       r_mis;
    logic [IDX_W-1:0]       r_ff;

    logic w_busy;
    logic w_start_ok;
    logic w_abort_ok;
    logic w_sample_ok;
    logic w_load;
    logic w_tc;

    assign w_busy      = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    // Abort outranks start everywhere; start is only honoured when not busy.
    assign w_start_ok  = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_abort_ok  = abort && w_busy;
    assign w_sample_ok = (r_state == ST_SAMPLE) && !abort;
    // The settle counter restarts whenever a new vector enters SETTLE.
    assign w_load      = w_start_ok || (w_sample_ok && (r_idx != LAST_IDX));

    combi_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .count (r_state == ST_SETTLE),
        .tc    (w_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_start_ok) w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (abort)     w_next = ST_IDLE;
                else if (w_tc) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)                  w_next = ST_IDLE;
                else if (r_idx == LAST_IDX) w_next = ST_DONE;
                else                        w_next = ST_SETTLE;
            end
            ST_DONE:   if (w_start_ok) w_next = ST_SETTLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Sweep datapath: clear and latch on start, park on abort, capture/compare in SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_exp <= '0;
            r_cap <= '0;
            r_mis <= '0;
            r_ff  <= '0;
        end else if (w_start_ok) begin
            r_idx <= '0;
            r_exp <= expected;
            r_cap <= '0;
            r_mis <= '0;
            r_ff  <= '0;
        end else if (w_abort_ok) begin
            // Partial results stay visible after an abort.
            r_idx <= '0;
        end else if (w_sample_ok) begin
            r_cap[r_idx] <= y_in;
            if (y_in != r_exp[r_idx]) begin
                // A zero count means no earlier vector has failed.
                r_mis <= r_mis + CNT_W'(1);
                if (r_mis == '0) begin
                    r_ff <= r_idx;
                end
            end
            if (r_idx != LAST_IDX) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign abcd         = r_idx;
    assign cap          = r_cap;
    assign busy         = w_busy;
    assign done         = (r_state == ST_DONE);
    assign pass         = (r_state == ST_DONE) && (r_mis == '0);
    assign mismatch_cnt = r_mis;
    assign first_fail   = r_ff;

endmodule

// File: tb/tb_combi_resp_checker.sv
// Bench for combi_resp_checker: table of sweep configurations with a
// scoreboard of expected results checked when done rises, plus hand-written
// abort, mid-sweep start, restart, reset and long-settle sequences.
module tb_combi_resp_checker;

    typedef struct {
        int          mode;      // 0: y = a^b^c^d, 1: stuck at 0, 2: stuck at 1
        logic [15:0] exp_in;
        logic [15:0] cap;
        int          mis;
        int          ff;
        int          pass;
    } vec_t;

    typedef struct {
        logic [15:0] cap;
        int          mis;
        int          ff;
        int          pass;
        int          start_cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'h0000;
    logic        y_in;
    logic [3:0]  abcd;
    logic [15:0] cap;
    logic        busy, done, pass;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;

    logic        start3 = 1'b0;
    logic        abort3 = 1'b0;
    logic [15:0] expected3 = 16'h6996;
    logic        y3;
    logic [3:0]  abcd3;
    logic [15:0] cap3;
    logic        busy3, done3, pass3;
    logic [4:0]  mis3;
    logic [3:0]  ff3;

    int   mode = 0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t q3[$];
    exp_t e0, e3;
    logic prev_done = 1'b0;
    logic prev_done3 = 1'b0;
    vec_t tbl[6];
    int   hold[16];

    combi_resp_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .expected     (expected),
        .y_in         (y_in),
        .abcd         (abcd),
        .cap          (cap),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail)
    );

    combi_resp_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start3),
        .abort        (abort3),
        .expected     (expected3),
        .y_in         (y3),
        .abcd         (abcd3),
        .cap          (cap3),
        .busy         (busy3),
        .done         (done3),
        .pass         (pass3),
        .mismatch_cnt (mis3),
        .first_fail   (ff3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the unit under test.
    always_comb begin
        y_in = 1'b0;
        case (mode)
            0:       y_in = ^abcd;
            1:       y_in = 1'b0;
            default: y_in = 1'b1;
        endcase
    end
    assign y3 = ^abcd3;

    task automatic chk(input string nm, input int got, input int req);
        n_total++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h) t=%0t", nm, got, got, req, req, $time);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic [15:0] c,
                                input int m, input int f, input int p, input int lat);
        chk({tag, "_cap"}, int'(c), int'(e.cap));
        chk({tag, "_mismatch_cnt"}, m, e.mis);
        chk({tag, "_first_fail"}, f, e.ff);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_latency"}, lat, e.lat);
    endtask

    // Scoreboard for the default-parameter instance.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            chk("sb_pending", q.size(), 1);
            if (q.size() > 0) begin
                e0 = q.pop_front();
                check_result("sweep", e0, cap, int'(mismatch_cnt), int'(first_fail), int'(pass), cyc - e0.start_cyc);
            end
        end
        prev_done = done;
    end

    // Scoreboard for the SETTLE_CYCLES=3 instance.
    always @(negedge clk) begin
        if (done3 && !prev_done3) begin
            chk("sb3_pending", q3.size(), 1);
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                check_result("sweep3", e3, cap3, int'(mis3), int'(ff3), int'(pass3), cyc - e3.start_cyc);
            end
        end
        prev_done3 = done3;
    end

    task automatic push(input logic [15:0] c, input int m, input int f, input int p);
        exp_t e;
        e.cap = c; e.mis = m; e.ff = f; e.pass = p;
        e.start_cyc = cyc + 1;
        e.lat = 32;
        q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_abcd(input logic [3:0] v, input int maxc);
        for (int k = 0; k < maxc && abcd != v; k++) @(negedge clk);
        chk("reach_abcd", int'(abcd), int'(v));
    endtask

    task automatic wait_done(input int maxc);
        for (int k = 0; k < maxc && !done; k++) @(negedge clk);
        chk("done_in_time", int'(done), 1);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        mode = v.mode;
        expected = v.exp_in;
        push(v.cap, v.mis, v.ff, v.pass);
        pulse_start();
        // One edge after start: previous results cleared, sweep running.
        chk("start_busy", int'(busy), 1);
        chk("start_done_low", int'(done), 0);
        chk("start_pass_low", int'(pass), 0);
        chk("start_cap_clr", int'(cap), 0);
        chk("start_mis_clr", int'(mismatch_cnt), 0);
        chk("start_ff_clr", int'(first_fail), 0);
        wait_done(40);
        chk("done_abcd", int'(abcd), 15);
        chk("done_busy", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 16'h6996, 16'h6996, 0,  0, 1};
        tbl[1] = '{1, 16'h6996, 16'h0000, 8,  1, 0};
        tbl[2] = '{2, 16'h0000, 16'hFFFF, 16, 0, 0};
        tbl[3] = '{0, 16'h6997, 16'h6996, 1,  0, 0};
        tbl[4] = '{0, 16'h6916, 16'h6996, 1,  7, 0};
        tbl[5] = '{1, 16'h0000, 16'h0000, 0,  0, 1};

        // Reset state.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_abcd", int'(abcd), 0);
        chk("rst_cap", int'(cap), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_mis", int'(mismatch_cnt), 0);
        chk("rst_ff", int'(first_fail), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven sweeps; each later start is a restart from DONE.
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Start pulse mid-sweep is ignored; latency stays 32.
        mode = 0;
        expected = 16'h6996;
        push(16'h6996, 0, 0, 1);
        pulse_start();
        wait_abcd(4'd3, 20);
        pulse_start();
        wait_done(40);
        // Identical re-run from DONE.
        run_vec(tbl[0]);

        // Abort while abcd=5.
        pulse_start();
        wait_abcd(4'd5, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_abcd", int'(abcd), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_cap_partial", int'(cap), 16'h0016);
        // Abort and start together in IDLE: abort wins, partial cap kept.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_prio_busy", int'(busy), 0);
        chk("abort_prio_cap", int'(cap), 16'h0016);
        // Full sweep after abort; expected changing mid-sweep has no effect.
        push(16'h6996, 0, 0, 1);
        pulse_start();
        expected = 16'h0000;
        wait_done(40);

        // Asynchronous reset mid-sweep at abcd=9.
        expected = 16'h6996;
        pulse_start();
        wait_abcd(4'd9, 30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_abcd", int'(abcd), 0);
        chk("arst_cap", int'(cap), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_mis", int'(mismatch_cnt), 0);
        chk("arst_ff", int'(first_fail), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Clean sweep after reset, with a stuck-0 unit for distinct results.
        mode = 1;
        push(16'h0000, 8, 1, 0);
        pulse_start();
        wait_done(40);

        // SETTLE_CYCLES=3: 64-cycle sweep, each vector held 4 cycles.
        for (int v = 0; v < 16; v++) hold[v] = 0;
        begin
            exp_t e;
            e.cap = 16'h6996; e.mis = 0; e.ff = 0; e.pass = 1;
            e.start_cyc = cyc + 1;
            e.lat = 64;
            q3.push_back(e);
        end
        start3 = 1'b1;
        for (int k = 0; k < 100 && !done3; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (busy3) hold[abcd3]++;
        end
        chk("done3_in_time", int'(done3), 1);
        for (int v = 0; v < 16; v++) chk($sformatf("hold3_v%0d", v), hold[v], 4);
        chk("done3_abcd", int'(abcd3), 15);

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size() + q3.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/combi_resp_checker.md
COMBI_RESP_CHECKER -- requirements
Module: combi_resp_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: clock cycles each input vector is held before the response is sampled (legal 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a 16-vector sweep.
REQ-005 SHALL have port abort, input, 1: terminates a running sweep.
REQ-006 SHALL have port expected, input, 16: golden truth table; bit i is the expected response for vector i.
REQ-007 SHALL have port y_in, input, 1: response of the 4-input combinational unit under test.
REQ-008 SHALL have port abcd, output, 4: applied vector; abcd[3]=a, abcd[2]=b, abcd[1]=c, abcd[0]=d; vector index = {a,b,c,d}.
REQ-009 SHALL have port cap, output, 16: captured truth table; bit i is y_in sampled for vector i.
REQ-010 SHALL have port busy, output, 1: high while a sweep runs.
REQ-011 SHALL have port done, output, 1: high after a sweep completes.
REQ-012 SHALL have port pass, output, 1: valid with done; high when cap equals expected.
REQ-013 SHALL have port mismatch_cnt, output, 5: number of mismatching vectors, 0..16.
REQ-014 SHALL have port first_fail, output, 4: index of the lowest mismatching vector; 0 when none.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE + start: SHALL go to SETTLE with index=0 and abcd=0; clear cap, mismatch_cnt, first_fail and the settle counter; latch expected.
REQ-017 SETTLE: SHALL hold abcd stable for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-018 SAMPLE, one cycle: SHALL write cap[index]<=y_in; on mismatch against the latched expected[index], SHALL increment mismatch_cnt, and SHALL set first_fail=index if this is the first mismatch.
REQ-019 SAMPLE with index<15: SHALL increment index and abcd and return to SETTLE; with index==15: SHALL go to DONE.
REQ-020 Sweep latency SHALL be 16*(SETTLE_CYCLES+1) cycles from the start edge to done high (32 cycles for the default).
REQ-021 DONE: SHALL hold done=1 and pass=(mismatch_cnt==0), and SHALL hold abcd=15 and all results until the next start.
REQ-022 start in DONE SHALL restart exactly as from IDLE, with done and pass falling on the following edge.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort while busy SHALL go to IDLE on the next edge with abcd=0, done=0, pass=0; cap and counters SHALL hold their partial values.
REQ-025 abort and start in the same cycle SHALL give abort priority.
REQ-026 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-027 Expected latching SHALL be the only point at which expected is used; changes to expected mid-sweep SHALL have no effect.
REQ-028 mismatch_cnt SHALL saturate naturally at 16 (all vectors fail) without wrap.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, with abcd=0, cap=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, index=0, settle counter=0, latched expected=0.
REQ-030 Reset asserted mid-sweep SHALL discard all results; the first start after release SHALL begin a clean sweep.

Structure
REQ-031 Package combi_chk_pkg SHALL hold the state encoding, VEC_COUNT=16, and the index width 4.
REQ-032 The settle counter SHALL be a sub-module, combi_settle_cnt (load, count, terminal-count flag); everything else SHALL live in combi_resp_checker.

Verification
REQ-033 Bench SHALL cover: y_in = a^b^c^d, expected=16'h6996, default parameter, start -> done 32 cycles later; cap=16'h6996, pass=1, mismatch_cnt=0, first_fail=0.
REQ-034 Bench SHALL cover: y_in stuck at 0, expected=16'h6996 -> cap=16'h0000, mismatch_cnt=8, first_fail=1, pass=0.
REQ-035 Bench SHALL cover: y_in stuck at 1, expected=16'h0000 -> mismatch_cnt=16, first_fail=0, pass=0.
REQ-036 Bench SHALL cover: abort while abcd=5 -> IDLE next edge, abcd=0, done=0; a later start yields a full 32-cycle sweep.
REQ-037 Bench SHALL cover: start pulsed at abcd=3 mid-sweep -> ignored, total latency still 32; restart from DONE -> results cleared, identical re-run.
REQ-038 Bench SHALL cover: rst_n low at abcd=9 -> outputs zero asynchronously; SETTLE_CYCLES=3 run -> done after 64 cycles, each abcd value held 4 cycles.
